// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between the I-cache (requester 0)
// and the D-cache (requester 1), one whole line transaction at a time.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-low reset
//   pN_enable_i / pN_write_i   requester N request (held until ack) and read/write select
//   pN_addr_i / pN_data_i      requester N line address and write data
//   pN_ack_o                   requester N transaction complete (mem_ack_i routed to owner)
//   p_data_o                   memory read data broadcast to both requesters
//   mem_enable_o/mem_write_o   memory transaction enable and write strobe
//   mem_addr_o/mem_data_o      memory address and write data (latched for the transaction)
//   mem_data_i/mem_ack_i       memory read data and one-cycle completion pulse
//   grant_o                    one-hot owner of the current transaction, 00 when idle
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256,
   parameter bit RR_EN  = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p0_enable_i,
   input  logic              p0_write_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_data_i,
   output logic              p0_ack_o,
   input  logic              p1_enable_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_data_i,
   output logic              p1_ack_o,
   output logic [DATA_W-1:0] p_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [1:0]        grant_o
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BUSY0 = 2'd1;
   localparam logic [1:0] BUSY1 = 2'd2;

   logic [1:0]        r_state;
   logic              r_last;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        w_grant;
   logic              w_idle;
   logic              w_req;
   logic              w_pick1;

   assign w_grant = {r_state == BUSY1, r_state == BUSY0};
   // The unused encoding behaves as IDLE so a corrupted state self-recovers.
   assign w_idle  = ~|w_grant;
   assign w_req   = p0_enable_i | p1_enable_i;
   // Requester 1 wins when alone, or on a tie when round-robin says it is not the last owner.
   assign w_pick1 = p1_enable_i & (~p0_enable_i | (RR_EN & ~r_last));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (w_idle) begin
         if (w_req) begin
            r_state <= w_pick1 ? BUSY1 : BUSY0;
            r_last  <= w_pick1;
            r_write <= w_pick1 ? p1_write_i : p0_write_i;
            r_addr  <= w_pick1 ? p1_addr_i : p0_addr_i;
            r_data  <= w_pick1 ? p1_data_i : p0_data_i;
         end else begin
            r_state <= IDLE;
         end
      end else if (mem_ack_i) begin
         r_state <= IDLE;
      end
   end

   assign grant_o      = w_grant;
   assign mem_enable_o = ~w_idle;
   assign mem_write_o  = r_write;
   assign mem_addr_o   = r_addr;
   assign mem_data_o   = r_data;
   assign p0_ack_o     = w_grant[0] & mem_ack_i;
   assign p1_ack_o     = w_grant[1] & mem_ack_i;
   assign p_data_o     = mem_data_i;
endmodule
